// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: turns iterator x/y/hs/vs/de into panel RGB.
// Scaled fetch from a double-buffered index framebuffer, 16-entry palette
// lookup, sideband delay matching and vsync-synchronised page flips.
// Optional build macro FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN replaces the
// framebuffer/palette colour with an x/y gradient test pattern.
module framebuffer_scanout #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int RAM_LATENCY = 1,
  localparam int FB_AW      = $clog2(2 * FB_W * FB_H)
) (
  input  logic               clk_rgb,
  input  logic               rst,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               hs,
  input  logic               vs,
  input  logic               de,
  output logic [FB_AW-1:0]   fb_addr,
  output logic               fb_rd,
  input  logic [3:0]         fb_data,
  input  logic               pal_we,
  input  logic [3:0]         pal_idx,
  input  logic [23:0]        pal_rgb,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               page,
  output logic               frame_start,
  output logic [23:0]        rgb,
  output logic               hs_o,
  output logic               vs_o,
  output logic               de_o
);

  // Sideband that travels alongside the RAM read.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       oob;
`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
    logic [7:0] x;
    logic [7:0] y;
`endif
  } sb_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  // ---------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------
  logic [31:0]      fx;
  logic [31:0]      fy;
  logic             in_range;
  logic [FB_AW-1:0] addr_next;

  // Scale screen coordinates down and form the linear page address.
  always_comb begin
    fx        = 32'(x) >> SCALE_SHIFT;
    fy        = 32'(y) >> SCALE_SHIFT;
    in_range  = (fx < 32'(FB_W)) && (fy < 32'(FB_H));
    addr_next = (page ? FB_AW'(FB_W * FB_H) : '0)
              + FB_AW'(fy) * FB_AW'(FB_W)
              + FB_AW'(fx);
  end

  // ---------------------------------------------------------------------
  // Stage A: registered address, read strobe and sideband
  // ---------------------------------------------------------------------
  sb_t a_sb;

  // Stage A captures the fetch address and the sideband for this pixel.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      fb_addr <= '0;
      fb_rd   <= 1'b0;
      a_sb    <= '0;
    end else begin
      fb_addr  <= addr_next;
`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
      fb_rd    <= 1'b0;
      a_sb.x   <= x[7:0];
      a_sb.y   <= y[7:0];
`else
      fb_rd    <= de & in_range;
`endif
      a_sb.hs  <= hs;
      a_sb.vs  <= vs;
      a_sb.de  <= de;
      a_sb.oob <= ~in_range;
    end
  end

  // ---------------------------------------------------------------------
  // RAM-latency matching delay line
  // ---------------------------------------------------------------------
  sb_t [RAM_LATENCY-1:0] rd_pipe;
  sb_t                   p_sb;

  if (RAM_LATENCY == 1) begin : g_rd_one
    // Single-cycle RAM: one sideband register.
    always_ff @(posedge clk_rgb) begin
      if (rst) rd_pipe <= '0;
      else     rd_pipe <= a_sb;
    end
  end else begin : g_rd_multi
    // Multi-cycle RAM: shift the sideband one slot per cycle.
    always_ff @(posedge clk_rgb) begin
      if (rst) rd_pipe <= '0;
      else     rd_pipe <= {rd_pipe[RAM_LATENCY-2:0], a_sb};
    end
  end

  assign p_sb = rd_pipe[RAM_LATENCY-1];

  // ---------------------------------------------------------------------
  // Palette register file
  // ---------------------------------------------------------------------
  logic [23:0] pal [16];

  // Palette write port; readers in the same cycle see the old entry.
  always_ff @(posedge clk_rgb) begin
    if (rst)         pal <= '{default: '0};
    else if (pal_we) pal[pal_idx] <= pal_rgb;
  end

  // ---------------------------------------------------------------------
  // Stage P: colour lookup and aligned sync outputs
  // ---------------------------------------------------------------------
  logic [23:0] pixel;

  // Pick the colour for the pixel leaving the RAM stage.
  always_comb begin
`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
    pixel = {p_sb.x, p_sb.y, 8'h80};
`else
    pixel = pal[p_sb.oob ? 4'h0 : fb_data];
`endif
  end

  // Stage P registers colour and sync, blanking colour outside de.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      rgb  <= '0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
      de_o <= 1'b0;
    end else begin
      rgb  <= p_sb.de ? pixel : '0;
      hs_o <= p_sb.hs;
      vs_o <= p_sb.vs;
      de_o <= p_sb.de;
    end
  end

  // ---------------------------------------------------------------------
  // Page flip and frame markers
  // ---------------------------------------------------------------------
  swap_state_t swap_state;
  swap_state_t swap_state_next;
  logic        vs_prev;
  logic        vs_rise;
  logic        flip;

  // Swap state register.
  always_ff @(posedge clk_rgb) begin
    if (rst) swap_state <= SWAP_IDLE;
    else     swap_state <= swap_state_next;
  end

  // A request arriving on the vsync edge itself flips without going pending.
  always_comb begin
    swap_state_next = swap_state;
    flip            = 1'b0;
    vs_rise         = vs & ~vs_prev;
    unique case (swap_state)
      SWAP_IDLE: begin
        if (swap_req) begin
          if (vs_rise) flip = 1'b1;
          else         swap_state_next = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (vs_rise) begin
          flip            = 1'b1;
          swap_state_next = SWAP_IDLE;
        end
      end
      default: swap_state_next = SWAP_IDLE;
    endcase
  end

  // Displayed page, flip acknowledge and frame-start pulse.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      page        <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      vs_prev     <= 1'b0;
    end else begin
      vs_prev     <= vs;
      swap_ack    <= flip;
      frame_start <= vs_prev & ~vs;
      if (flip) page <= ~page;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout (default build, RAM_LATENCY = 1).
// A cycle model built from pixel history checks every output each cycle;
// a vector table and short directed sequences cover the named corners.
`timescale 1ns/1ps
module tb_framebuffer_scanout;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int RAM_SIZE = 2 * FB_W * FB_H;

  logic        clk_rgb = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        hs, vs, de;
  logic [15:0] fb_addr;
  logic        fb_rd;
  logic [3:0]  fb_data;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [23:0] pal_rgb;
  logic        swap_req, swap_ack, page, frame_start;
  logic [23:0] rgb;
  logic        hs_o, vs_o, de_o;

  framebuffer_scanout #(
    .X_WIDTH(10), .Y_WIDTH(9), .FB_W(FB_W), .FB_H(FB_H),
    .SCALE_SHIFT(2), .RAM_LATENCY(1)
  ) dut (
    .clk_rgb(clk_rgb), .rst(rst), .x(x), .y(y), .hs(hs), .vs(vs), .de(de),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .swap_req(swap_req), .swap_ack(swap_ack), .page(page),
    .frame_start(frame_start), .rgb(rgb), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o)
  );

  always #5 clk_rgb = ~clk_rgb;

  // Framebuffer RAM with one cycle of read latency.
  logic [3:0] mem [RAM_SIZE];
  always @(posedge clk_rgb) fb_data <= mem[fb_addr];

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
    bit page;
  } pix_t;

  pix_t        h [3];          // h[0] = last cycle's inputs, h[2] = three cycles ago
  logic [23:0] m_pal [16];
  bit          m_page, m_pend, m_prev_vs;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic bit in_fb(pix_t p);
    return (p.x / 4 < FB_W) && (p.y / 4 < FB_H);
  endfunction

  function automatic int addr_of(pix_t p);
    return (p.page ? FB_W * FB_H : 0) + (p.y / 4) * FB_W + p.x / 4;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic step();
    pix_t        r;
    bit          r_rst, r_req, r_we;
    logic [3:0]  r_idx;
    logic [23:0] r_val;
    bit          e_ack, e_fs, e_rd;
    logic [23:0] e_rgb;
    r.x = int'(x); r.y = int'(y); r.hs = hs; r.vs = vs; r.de = de; r.page = m_page;
    r_rst = rst; r_req = swap_req; r_we = pal_we; r_idx = pal_idx; r_val = pal_rgb;
    @(posedge clk_rgb);
    #1;
    if (r_rst) begin
      for (int i = 0; i < 3; i++) h[i] = '{default: 0};
      for (int i = 0; i < 16; i++) m_pal[i] = '0;
      m_page = 0; m_pend = 0; m_prev_vs = 0;
      e_ack = 0; e_fs = 0;
    end else begin
      e_ack = 0;
      if (r.vs && !m_prev_vs && (m_pend || r_req)) begin
        e_ack  = 1;
        m_page = !m_page;
        m_pend = 0;
      end else if (r_req) begin
        m_pend = 1;
      end
      e_fs      = m_prev_vs && !r.vs;
      m_prev_vs = r.vs;
      h[2] = h[1]; h[1] = h[0]; h[0] = r;
    end
    e_rd  = h[0].de && in_fb(h[0]);
    e_rgb = !h[2].de ? 24'h0 : m_pal[in_fb(h[2]) ? mem[addr_of(h[2])] : 4'h0];
    if (!r_rst && r_we) m_pal[r_idx] = r_val;

    chk("m_rgb",   32'(rgb),         32'(e_rgb));
    chk("m_de_o",  32'(de_o),        32'(h[2].de));
    chk("m_hs_o",  32'(hs_o),        32'(h[2].hs));
    chk("m_vs_o",  32'(vs_o),        32'(h[2].vs));
    chk("m_fb_rd", 32'(fb_rd),       32'(e_rd));
    if (e_rd) chk("m_fb_addr", 32'(fb_addr), 32'(addr_of(h[0])));
    chk("m_page",  32'(page),        32'(m_page));
    chk("m_ack",   32'(swap_ack),    32'(e_ack));
    chk("m_fs",    32'(frame_start), 32'(e_fs));
  endtask

  task automatic idle_inputs();
    x = '0; y = '0; hs = 0; vs = 0; de = 0;
    swap_req = 0; pal_we = 0; pal_idx = '0; pal_rgb = '0;
  endtask

  task automatic write_pal(logic [3:0] idx, logic [23:0] val);
    pal_we = 1; pal_idx = idx; pal_rgb = val;
    step();
    pal_we = 0;
  endtask

  // ---------------------------------------------------------------------
  // Directed address/colour vectors (page 0)
  // ---------------------------------------------------------------------
  typedef struct {
    int          x;
    int          y;
    bit          de;
    int          exp_addr;
    bit          exp_rd;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{x: 13,   y: 9,   de: 1, exp_addr: 323,   exp_rd: 1, exp_rgb: 24'h12AB34};
    vt[1] = '{x: 0,    y: 0,   de: 1, exp_addr: 0,     exp_rd: 1, exp_rgb: 24'h111111};
    vt[2] = '{x: 639,  y: 479, de: 1, exp_addr: 19199, exp_rd: 1, exp_rgb: 24'hF0F0F0};
    vt[3] = '{x: 19,   y: 7,   de: 1, exp_addr: 164,   exp_rd: 1, exp_rgb: 24'h909090};
    vt[4] = '{x: 700,  y: 5,   de: 1, exp_addr: 0,     exp_rd: 0, exp_rgb: 24'h0A0B0C};
    vt[5] = '{x: 0,    y: 480, de: 1, exp_addr: 0,     exp_rd: 0, exp_rgb: 24'h0A0B0C};
    vt[6] = '{x: 640,  y: 0,   de: 1, exp_addr: 0,     exp_rd: 0, exp_rgb: 24'h0A0B0C};
    vt[7] = '{x: 700,  y: 5,   de: 0, exp_addr: 0,     exp_rd: 0, exp_rgb: 24'h000000};

    for (int i = 0; i < RAM_SIZE; i++) mem[i] = 4'($urandom);
    mem[323] = 4'd5; mem[0] = 4'd1; mem[19199] = 4'd15; mem[164] = 4'd9; mem[805] = 4'd3;

    // Reset state
    rst = 1; idle_inputs();
    step(); step();
    chk("reset_rgb",   32'(rgb),   32'h0);
    chk("reset_de_o",  32'(de_o),  32'h0);
    chk("reset_page",  32'(page),  32'h0);
    chk("reset_fb_rd", 32'(fb_rd), 32'h0);
    rst = 0;

    write_pal(4'd0,  24'h0A0B0C);
    write_pal(4'd1,  24'h111111);
    write_pal(4'd3,  24'h333333);
    write_pal(4'd5,  24'h12AB34);
    write_pal(4'd9,  24'h909090);
    write_pal(4'd15, 24'hF0F0F0);

    // Timing alignment: single de/hs pulse emerges exactly 3 cycles later
    x = '0; y = '0; de = 1; hs = 1;
    step();
    de = 0; hs = 0;
    chk("align_de_c1", 32'(de_o), 32'h0);
    step();
    chk("align_de_c2", 32'(de_o), 32'h0);
    chk("align_hs_c2", 32'(hs_o), 32'h0);
    step();
    chk("align_de_c3", 32'(de_o), 32'h1);
    chk("align_hs_c3", 32'(hs_o), 32'h1);
    step();
    chk("align_de_c4", 32'(de_o), 32'h0);

    // Address / border vectors
    for (int i = 0; i < 8; i++) begin
      x = 10'(vt[i].x); y = 9'(vt[i].y); de = vt[i].de;
      step();
      chk("tbl_fb_rd", 32'(fb_rd), 32'(vt[i].exp_rd));
      if (vt[i].exp_rd) chk("tbl_fb_addr", 32'(fb_addr), 32'(vt[i].exp_addr));
      de = 0;
      step(); step();
      chk("tbl_de_o", 32'(de_o), 32'(vt[i].de));
      chk("tbl_rgb",  32'(rgb),  32'(vt[i].exp_rgb));
    end

    // Palette hazard: write index 3 on the cycle stage P reads it
    x = 10'd20; y = 9'd20; de = 1;
    step();
    de = 0;
    step();
    pal_we = 1; pal_idx = 4'd3; pal_rgb = 24'hFFFFFF;
    step();
    pal_we = 0;
    chk("hazard_old", 32'(rgb), 32'h333333);
    de = 1;
    step();
    de = 0;
    step(); step();
    chk("hazard_new", 32'(rgb), 32'hFFFFFF);

    // Page flip: pending request waits for vs rise, one flip per vsync
    swap_req = 1;
    step();
    swap_req = 0;
    chk("flip_wait_page", 32'(page), 32'h0);
    chk("flip_wait_ack",  32'(swap_ack), 32'h0);
    step(); step();
    swap_req = 1;
    step();
    swap_req = 0;
    chk("flip_wait2_page", 32'(page), 32'h0);
    vs = 1;
    step();
    chk("flip_page", 32'(page), 32'h1);
    chk("flip_ack",  32'(swap_ack), 32'h1);
    step();
    chk("flip_ack_pulse", 32'(swap_ack), 32'h0);
    vs = 0;
    step();
    chk("frame_start", 32'(frame_start), 32'h1);
    step();
    chk("frame_start_pulse", 32'(frame_start), 32'h0);
    vs = 1;
    step();
    chk("single_flip_page", 32'(page), 32'h1);
    chk("single_flip_ack",  32'(swap_ack), 32'h0);
    vs = 0; x = '0; y = '0; de = 1;
    step();
    de = 0;
    chk("page1_addr", 32'(fb_addr), 32'd19200);
    chk("page1_rd",   32'(fb_rd),   32'h1);

    // Reset mid-line with de held high
    x = 10'd100; y = 9'd40; de = 1;
    step(); step(); step();
    rst = 1;
    step();
    rst = 0;
    chk("rst_de_o", 32'(de_o), 32'h0);
    chk("rst_rgb",  32'(rgb),  32'h0);
    chk("rst_page", 32'(page), 32'h0);
    step();
    chk("refill_c1", 32'(de_o), 32'h0);
    step();
    chk("refill_c2", 32'(de_o), 32'h0);
    step();
    chk("refill_c3", 32'(de_o), 32'h1);

    // Request on the same cycle as the vs edge is taken by that edge
    de = 0; vs = 0;
    step();
    vs = 1; swap_req = 1;
    step();
    swap_req = 0; vs = 0;
    chk("same_edge_page", 32'(page), 32'h1);
    chk("same_edge_ack",  32'(swap_ack), 32'h1);
    step();

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      x        = 10'($urandom_range(0, 1023));
      y        = 9'($urandom_range(0, 511));
      de       = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0)  hs = ~hs;
      if ($urandom_range(0, 24) == 0) vs = ~vs;
      swap_req = ($urandom_range(0, 39) == 0);
      pal_we   = ($urandom_range(0, 5) == 0);
      pal_idx  = 4'($urandom);
      pal_rgb  = 24'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
